// File: rtl/user_stream_switch_c0.sv
// Per-channel AXI-Stream switch: each host-sink packet goes to host loopback, card, both or is
// dropped, with one registered output stage per channel and saturating packet/drop counters.
module user_stream_switch_c0 #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = 6,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [2*N_CHAN-1:0]             ctrl_mode,
  input  logic                            ctrl_clear,
  input  logic [N_CHAN*DATA_BITS-1:0]     s_tdata,
  input  logic [N_CHAN*DATA_BITS/8-1:0]   s_tkeep,
  input  logic [N_CHAN*ID_BITS-1:0]       s_tid,
  input  logic [N_CHAN-1:0]               s_tlast,
  input  logic [N_CHAN-1:0]               s_tvalid,
  output logic [N_CHAN-1:0]               s_tready,
  output logic [N_CHAN*DATA_BITS-1:0]     mh_tdata,
  output logic [N_CHAN*DATA_BITS/8-1:0]   mh_tkeep,
  output logic [N_CHAN*ID_BITS-1:0]       mh_tid,
  output logic [N_CHAN-1:0]               mh_tlast,
  output logic [N_CHAN-1:0]               mh_tvalid,
  input  logic [N_CHAN-1:0]               mh_tready,
  output logic [N_CHAN*DATA_BITS-1:0]     mc_tdata,
  output logic [N_CHAN*DATA_BITS/8-1:0]   mc_tkeep,
  output logic [N_CHAN*ID_BITS-1:0]       mc_tid,
  output logic [N_CHAN-1:0]               mc_tlast,
  output logic [N_CHAN-1:0]               mc_tvalid,
  input  logic [N_CHAN-1:0]               mc_tready,
  output logic [N_CHAN*CNT_BITS-1:0]      pkt_cnt,
  output logic [N_CHAN*CNT_BITS-1:0]      drop_cnt
);

  localparam int unsigned KeepBits = DATA_BITS / 8;

  typedef enum logic [2:0] {StIdle, StDrop, StHost, StCard, StBoth} state_e;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    state_e               state_q, state_d;
    logic [1:0]           mode_now, route;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [KeepBits-1:0]  keep_q, keep_d;
    logic [ID_BITS-1:0]   id_q, id_d;
    logic                 last_q, last_d;
    logic                 pend_h_q, pend_h_d, pend_c_q, pend_c_d;
    logic [CNT_BITS-1:0]  pkt_q, pkt_d, drop_q, drop_d;
    logic                 stage_empty, stage_drain, ready, accept, beat_last;

    assign mode_now  = ctrl_mode[2*c +: 2];
    assign beat_last = s_tlast[c];

    // Mid-packet the route is locked by the state; only an idle channel follows ctrl_mode.
    always_comb begin
      unique case (state_q)
        StDrop:  route = 2'd0;
        StHost:  route = 2'd1;
        StCard:  route = 2'd2;
        StBoth:  route = 2'd3;
        default: route = mode_now;
      endcase
    end

    assign stage_empty = ~pend_h_q & ~pend_c_q;
    assign stage_drain = (~pend_h_q | mh_tready[c]) & (~pend_c_q | mc_tready[c]);
    assign ready       = aresetn & ((route == 2'd0) ? stage_empty : stage_drain);
    assign accept      = s_tvalid[c] & ready;

    always_comb begin
      state_d = state_q;
      if (accept) begin
        if (beat_last) begin
          state_d = StIdle;
        end else if (state_q == StIdle) begin
          unique case (mode_now)
            2'd0:    state_d = StDrop;
            2'd1:    state_d = StHost;
            2'd2:    state_d = StCard;
            default: state_d = StBoth;
          endcase
        end
      end
    end

    always_comb begin
      data_d   = data_q;
      keep_d   = keep_q;
      id_d     = id_q;
      last_d   = last_q;
      pend_h_d = pend_h_q & ~mh_tready[c];
      pend_c_d = pend_c_q & ~mc_tready[c];
      // Dropped beats never occupy the stage.
      if (accept && (route != 2'd0)) begin
        data_d   = s_tdata[c*DATA_BITS +: DATA_BITS];
        keep_d   = s_tkeep[c*KeepBits +: KeepBits];
        id_d     = s_tid[c*ID_BITS +: ID_BITS];
        last_d   = beat_last;
        pend_h_d = route[0];
        pend_c_d = route[1];
      end
    end

    always_comb begin
      pkt_d  = pkt_q;
      drop_d = drop_q;
      if (accept && beat_last) begin
        if (route == 2'd0) begin
          if (drop_q != '1) drop_d = drop_q + CNT_BITS'(1);
        end else begin
          if (pkt_q != '1) pkt_d = pkt_q + CNT_BITS'(1);
        end
      end
      if (ctrl_clear) begin
        pkt_d  = '0;
        drop_d = '0;
      end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state_q  <= StIdle;
        data_q   <= '0;
        keep_q   <= '0;
        id_q     <= '0;
        last_q   <= 1'b0;
        pend_h_q <= 1'b0;
        pend_c_q <= 1'b0;
        pkt_q    <= '0;
        drop_q   <= '0;
      end else begin
        state_q  <= state_d;
        data_q   <= data_d;
        keep_q   <= keep_d;
        id_q     <= id_d;
        last_q   <= last_d;
        pend_h_q <= pend_h_d;
        pend_c_q <= pend_c_d;
        pkt_q    <= pkt_d;
        drop_q   <= drop_d;
      end
    end

    assign s_tready[c]                        = ready;
    assign mh_tdata[c*DATA_BITS +: DATA_BITS] = data_q;
    assign mh_tkeep[c*KeepBits +: KeepBits]   = keep_q;
    assign mh_tid[c*ID_BITS +: ID_BITS]       = id_q;
    assign mh_tlast[c]                        = last_q;
    assign mh_tvalid[c]                       = pend_h_q;
    assign mc_tdata[c*DATA_BITS +: DATA_BITS] = data_q;
    assign mc_tkeep[c*KeepBits +: KeepBits]   = keep_q;
    assign mc_tid[c*ID_BITS +: ID_BITS]       = id_q;
    assign mc_tlast[c]                        = last_q;
    assign mc_tvalid[c]                       = pend_c_q;
    assign pkt_cnt[c*CNT_BITS +: CNT_BITS]    = pkt_q;
    assign drop_cnt[c*CNT_BITS +: CNT_BITS]   = drop_q;
  end

endmodule

// File: tb/tb_user_stream_switch_c0.sv
// Bench for user_stream_switch_c0: random traffic per channel, checked against a packet-level
// routing model (expected beat queues per output plus saturating counters).
module tb_user_stream_switch_c0;
  localparam int unsigned N = 4, DB = 64, IB = 6, CB = 4, KB = DB / 8;
  localparam int unsigned BW = 1 + IB + KB + DB;
  localparam int BUDGET = 200;
  typedef logic [BW-1:0] beat_t;
  localparam logic [CB-1:0] CMAX = '1;

  logic aclk = 1'b0, aresetn = 1'b0, ctrl_clear = 1'b0;
  logic [2*N-1:0]  ctrl_mode;
  logic [N*DB-1:0] s_tdata, mh_tdata, mc_tdata;
  logic [N*KB-1:0] s_tkeep, mh_tkeep, mc_tkeep;
  logic [N*IB-1:0] s_tid, mh_tid, mc_tid;
  logic [N-1:0]    s_tlast, s_tvalid, s_tready, mh_tlast, mh_tvalid, mc_tlast, mc_tvalid;
  logic [N-1:0]    mh_tready = '0, mc_tready = '0;
  logic [N*CB-1:0] pkt_cnt, drop_cnt;

  logic [1:0]    mode [N];
  logic [DB-1:0] sd [N];
  logic [KB-1:0] sk [N];
  logic [IB-1:0] si [N];
  logic          sl [N], sv [N];
  int            h_pat [N], c_pat [N];

  beat_t exp_h [N][$], exp_c [N][$], obs_h [N][$], obs_c [N][$];
  logic [1:0]    pmode [N];
  bit            in_pkt [N], prev_h [N], prev_c [N];
  beat_t         prev_hb [N], prev_cb [N];
  logic [CB-1:0] m_pkt [N], m_drop [N];
  int viol = 0, cyc = 0, vectors = 0, miscompares = 0;

  for (genvar c = 0; c < N; c++) begin : g_pack
    assign ctrl_mode[2*c +: 2] = mode[c];
    assign s_tdata[c*DB +: DB] = sd[c];
    assign s_tkeep[c*KB +: KB] = sk[c];
    assign s_tid[c*IB +: IB]   = si[c];
    assign s_tlast[c]          = sl[c];
    assign s_tvalid[c]         = sv[c];
  end

  user_stream_switch_c0 #(.N_CHAN(N), .DATA_BITS(DB), .ID_BITS(IB), .CNT_BITS(CB)) dut (
    .aclk(aclk), .aresetn(aresetn), .ctrl_mode(ctrl_mode), .ctrl_clear(ctrl_clear),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tid(s_tid), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .mh_tdata(mh_tdata), .mh_tkeep(mh_tkeep), .mh_tid(mh_tid), .mh_tlast(mh_tlast),
    .mh_tvalid(mh_tvalid), .mh_tready(mh_tready),
    .mc_tdata(mc_tdata), .mc_tkeep(mc_tkeep), .mc_tid(mc_tid), .mc_tlast(mc_tlast),
    .mc_tvalid(mc_tvalid), .mc_tready(mc_tready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic beat_t in_b(input int c);
    return {sl[c], si[c], sk[c], sd[c]};
  endfunction
  function automatic beat_t out_h(input int c);
    return {mh_tlast[c], mh_tid[c*IB +: IB], mh_tkeep[c*KB +: KB], mh_tdata[c*DB +: DB]};
  endfunction
  function automatic beat_t out_c(input int c);
    return {mc_tlast[c], mc_tid[c*IB +: IB], mc_tkeep[c*KB +: KB], mc_tdata[c*DB +: DB]};
  endfunction

  function automatic bit pat_val(input int p);
    case (p)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'($urandom);
      default: return (cyc % 4) == 3;
    endcase
  endfunction

  // Downstream ready patterns, updated just after each rising edge.
  initial forever begin
    @(posedge aclk);
    #1;
    cyc++;
    for (int c = 0; c < N; c++) begin
      mh_tready[c] = pat_val(h_pat[c]);
      mc_tready[c] = pat_val(c_pat[c]);
    end
  end

  // Reference model: routes whole packets by the mode seen at their first accepted beat.
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      for (int c = 0; c < N; c++) begin
        in_pkt[c] = 0; prev_h[c] = 0; prev_c[c] = 0;
        m_pkt[c] = '0; m_drop[c] = '0;
        exp_h[c].delete(); exp_c[c].delete();
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (s_tready[c] && ((mh_tvalid[c] && !mh_tready[c]) || (mc_tvalid[c] && !mc_tready[c])))
          viol++;
        if (prev_h[c] && (!mh_tvalid[c] || out_h(c) !== prev_hb[c])) viol++;
        if (prev_c[c] && (!mc_tvalid[c] || out_c(c) !== prev_cb[c])) viol++;
        if (sv[c] && s_tready[c]) begin
          if (!in_pkt[c]) pmode[c] = mode[c];
          if (pmode[c][0]) exp_h[c].push_back(in_b(c));
          if (pmode[c][1]) exp_c[c].push_back(in_b(c));
          in_pkt[c] = !sl[c];
          if (sl[c]) begin
            if (pmode[c] == 2'd0) begin
              if (m_drop[c] != CMAX) m_drop[c]++;
            end else if (m_pkt[c] != CMAX) m_pkt[c]++;
          end
        end
        if (mh_tvalid[c] && mh_tready[c]) obs_h[c].push_back(out_h(c));
        if (mc_tvalid[c] && mc_tready[c]) obs_c[c].push_back(out_c(c));
        prev_h[c] = mh_tvalid[c] && !mh_tready[c]; prev_hb[c] = out_h(c);
        prev_c[c] = mc_tvalid[c] && !mc_tready[c]; prev_cb[c] = out_c(c);
      end
      if (ctrl_clear) for (int c = 0; c < N; c++) begin m_pkt[c] = '0; m_drop[c] = '0; end
    end
  end

  // Number of differing beats between observed and expected streams (size gap included).
  function automatic int q_diff(input int c, input bit host);
    beat_t o[$], e[$];
    int d;
    if (host) begin o = obs_h[c]; e = exp_h[c]; end
    else begin o = obs_c[c]; e = exp_c[c]; end
    d = (o.size() > e.size()) ? o.size() - e.size() : e.size() - o.size();
    for (int i = 0; i < o.size() && i < e.size(); i++) if (o[i] !== e[i]) d++;
    return d;
  endfunction

  task automatic sync();
    @(posedge aclk);
    #1;
  endtask

  task automatic flush();
    for (int c = 0; c < N; c++) begin
      exp_h[c].delete(); exp_c[c].delete(); obs_h[c].delete(); obs_c[c].delete();
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < N; c++) begin h_pat[c] = 0; c_pat[c] = 0; end
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic set_beat(input int c, input bit last);
    sd[c] = DB'({$urandom, $urandom});
    sk[c] = KB'($urandom);
    si[c] = IB'($urandom);
    sl[c] = last;
    sv[c] = 1'b1;
  endtask

  // Sends one packet on channel c; optionally changes ctrl_mode when beat sw_at is presented.
  task automatic send_pkt(input int c, input int n, input int sw_at, input logic [1:0] sw_mode,
                          output int cycles);
    bit ok;
    cycles = 0;
    for (int b = 0; b < n; b++) begin
      if (b == sw_at) mode[c] = sw_mode;
      set_beat(c, b == n - 1);
      ok = 0;
      for (int w = 0; w < BUDGET && !ok; w++) begin
        @(negedge aclk);
        ok = s_tready[c];
        @(posedge aclk);
        #1;
        cycles++;
      end
      if (!ok) begin
        vectors++; miscompares++;
        $display("FAIL s_tready timeout ch%0d beat %0d: got no accept want accept in %0d cycles",
                 c, b, BUDGET);
        sv[c] = 1'b0;
        return;
      end
    end
    sv[c] = 1'b0;
  endtask

  task automatic test_reset();
    h_pat[0] = 1;
    sv[0] = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    vectors++;
    if ({mh_tvalid, mc_tvalid, s_tready} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got mh_tvalid=%b mc_tvalid=%b s_tready=%b want all 0",
               mh_tvalid, mc_tvalid, s_tready);
    end
    vectors++;
    if ({pkt_cnt, drop_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset counters: got pkt=%h drop=%h want 0", pkt_cnt, drop_cnt);
    end
    sv[0] = 1'b0;
    #1 aresetn = 1'b1;
    sync();
    mode[0] = 2'd1;
    set_beat(0, 1'b0);
    sync();
    set_beat(0, 1'b0);
    @(negedge aclk);
    vectors++;
    if (mh_tvalid[0] !== 1'b1 || s_tready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL stalled beat ch0: got mh_tvalid=%b s_tready=%b want 1 0",
               mh_tvalid[0], s_tready[0]);
    end
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if ({mh_tvalid, mc_tvalid, s_tready} !== '0) begin
      miscompares++;
      $display("FAIL async reset mid-packet: got mh_tvalid=%b mc_tvalid=%b s_tready=%b want 0",
               mh_tvalid, mc_tvalid, s_tready);
    end
    sv[0] = 1'b0;
    @(negedge aclk);
    #1 aresetn = 1'b1;
    sync();
    flush();
    h_pat[0] = 0;
    mode[0] = 2'd2;
    begin
      int cy;
      send_pkt(0, 1, -1, 2'd0, cy);
    end
    drain(5);
    @(negedge aclk);
    vectors++;
    if (obs_h[0].size() !== 0 || obs_c[0].size() !== 1 || q_diff(0, 0) !== 0) begin
      miscompares++;
      $display("FAIL post-reset mode 2 beat: got mh=%0d mc=%0d beats (%0d diffs) want 0 1 (0)",
               obs_h[0].size(), obs_c[0].size(), q_diff(0, 0));
    end
    vectors++;
    if (pkt_cnt[0 +: CB] !== 4'd1) begin
      miscompares++;
      $display("FAIL post-reset pkt_cnt0: got %0d want 1", pkt_cnt[0 +: CB]);
    end
    sync();
  endtask

  task automatic test_host_stream();
    beat_t bts [8];
    flush();
    mode[0] = 2'd1;
    drain(2);
    for (int b = 0; b < 8; b++) begin
      set_beat(0, b == 7);
      bts[b] = in_b(0);
      @(negedge aclk);
      vectors++;
      if (s_tready[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL no-bubble s_tready0 beat %0d: got %b want 1", b, s_tready[0]);
      end
      if (b > 0) begin
        vectors++;
        if (mh_tvalid[0] !== 1'b1 || out_h(0) !== bts[b-1]) begin
          miscompares++;
          $display("FAIL 1-cycle latency ch0 beat %0d: got valid=%b beat=%h want 1 %h",
                   b - 1, mh_tvalid[0], out_h(0), bts[b-1]);
        end
      end
      sync();
    end
    sv[0] = 1'b0;
    @(negedge aclk);
    vectors++;
    if (mh_tvalid[0] !== 1'b1 || out_h(0) !== bts[7]) begin
      miscompares++;
      $display("FAIL last beat ch0: got valid=%b beat=%h want 1 %h", mh_tvalid[0], out_h(0), bts[7]);
    end
    drain(3);
    @(negedge aclk);
    vectors++;
    if (obs_h[0].size() !== 8 || q_diff(0, 1) !== 0 || obs_c[0].size() !== 0) begin
      miscompares++;
      $display("FAIL host stream ch0: got mh=%0d mc=%0d beats (%0d diffs) want 8 0 (0)",
               obs_h[0].size(), obs_c[0].size(), q_diff(0, 1));
    end
    vectors++;
    if (pkt_cnt[0 +: CB] !== m_pkt[0]) begin
      miscompares++;
      $display("FAIL pkt_cnt0: got %0d want %0d", pkt_cnt[0 +: CB], m_pkt[0]);
    end
    sync();
  endtask

  task automatic test_broadcast();
    int cy, v0;
    flush();
    v0 = viol;
    mode[1] = 2'd3;
    c_pat[1] = 3;
    sync();
    send_pkt(1, 4, -1, 2'd0, cy);
    drain(6);
    @(negedge aclk);
    vectors++;
    if (obs_h[1].size() !== 4 || obs_c[1].size() !== 4 || q_diff(1, 1) + q_diff(1, 0) !== 0) begin
      miscompares++;
      $display("FAIL broadcast ch1: got mh=%0d mc=%0d beats (%0d diffs) want 4 4 (0)",
               obs_h[1].size(), obs_c[1].size(), q_diff(1, 1) + q_diff(1, 0));
    end
    vectors++;
    if (cy < 10 || viol !== v0) begin
      miscompares++;
      $display("FAIL broadcast backpressure ch1: got %0d cycles %0d violations want >=10 0",
               cy, viol - v0);
    end
    vectors++;
    if (pkt_cnt[CB +: CB] !== 4'd1) begin
      miscompares++;
      $display("FAIL pkt_cnt1: got %0d want 1", pkt_cnt[CB +: CB]);
    end
    sync();
  endtask

  task automatic test_mode_switch();
    int cy;
    flush();
    mode[0] = 2'd1;
    send_pkt(0, 6, 3, 2'd2, cy);
    send_pkt(0, 3, -1, 2'd0, cy);
    drain(5);
    @(negedge aclk);
    vectors++;
    if (obs_h[0].size() !== 6 || obs_c[0].size() !== 3 || q_diff(0, 1) + q_diff(0, 0) !== 0) begin
      miscompares++;
      $display("FAIL mid-packet mode switch ch0: got mh=%0d mc=%0d beats (%0d diffs) want 6 3 (0)",
               obs_h[0].size(), obs_c[0].size(), q_diff(0, 1) + q_diff(0, 0));
    end
    sync();
  endtask

  task automatic test_drop_clear();
    int cy;
    flush();
    mode[2] = 2'd0;
    h_pat[2] = 2;
    c_pat[2] = 2;
    for (int k = 0; k < 5; k++) send_pkt(2, $urandom_range(1, 4), -1, 2'd0, cy);
    drain(3);
    @(negedge aclk);
    vectors++;
    if (obs_h[2].size() !== 0 || obs_c[2].size() !== 0) begin
      miscompares++;
      $display("FAIL drop outputs ch2: got mh=%0d mc=%0d beats want 0 0",
               obs_h[2].size(), obs_c[2].size());
    end
    vectors++;
    if (drop_cnt[2*CB +: CB] !== 4'd5 || pkt_cnt[2*CB +: CB] !== 4'd0 ||
        drop_cnt[2*CB +: CB] !== m_drop[2]) begin
      miscompares++;
      $display("FAIL drop counters ch2: got drop=%0d pkt=%0d want 5 0",
               drop_cnt[2*CB +: CB], pkt_cnt[2*CB +: CB]);
    end
    sync();
    ctrl_clear = 1'b1;
    send_pkt(2, 1, -1, 2'd0, cy);
    ctrl_clear = 1'b0;
    drain(2);
    @(negedge aclk);
    vectors++;
    if ({pkt_cnt, drop_cnt} !== '0 || m_drop[2] !== '0) begin
      miscompares++;
      $display("FAIL clear beats increment: got pkt=%h drop=%h want 0", pkt_cnt, drop_cnt);
    end
    sync();
  endtask

  task automatic test_saturate();
    int cy;
    flush();
    mode[0] = 2'd1;
    h_pat[0] = 1;
    mode[3] = 2'd2;
    c_pat[3] = 2;
    sync();
    set_beat(0, 1'b0);
    for (int k = 0; k < 20; k++) send_pkt(3, $urandom_range(1, 3), -1, 2'd0, cy);
    @(negedge aclk);
    vectors++;
    if (s_tready[0] !== 1'b0 || mh_tvalid[0] !== 1'b1 || obs_h[0].size() !== 0) begin
      miscompares++;
      $display("FAIL stalled ch0 during ch3 traffic: got s_tready=%b mh_tvalid=%b want 0 1",
               s_tready[0], mh_tvalid[0]);
    end
    vectors++;
    if (pkt_cnt[3*CB +: CB] !== 4'd15 || pkt_cnt[3*CB +: CB] !== m_pkt[3]) begin
      miscompares++;
      $display("FAIL saturating pkt_cnt3: got %0d want 15", pkt_cnt[3*CB +: CB]);
    end
    sync();
    sv[0] = 1'b0;
    h_pat[0] = 0;
    send_pkt(0, 1, -1, 2'd0, cy);
    drain(5);
    @(negedge aclk);
    vectors++;
    if (q_diff(0, 1) !== 0 || q_diff(3, 0) !== 0 || obs_c[3].size() !== exp_c[3].size()) begin
      miscompares++;
      $display("FAIL ch0/ch3 streams after release: got %0d/%0d diffs want 0/0",
               q_diff(0, 1), q_diff(3, 0));
    end
    sync();
  endtask

  task automatic run_chan(input int c);
    int cy;
    for (int k = 0; k < 8; k++) begin
      mode[c] = 2'($urandom);
      send_pkt(c, $urandom_range(1, 5), $urandom_range(0, 6), 2'($urandom), cy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    flush();
    v0 = viol;
    for (int c = 0; c < N; c++) begin h_pat[c] = 2; c_pat[c] = 2; end
    sync();
    fork
      begin run_chan(0); end
      begin run_chan(1); end
      begin run_chan(2); end
      begin run_chan(3); end
    join
    drain(10);
    @(negedge aclk);
    for (int c = 0; c < N; c++) begin
      vectors++;
      if (q_diff(c, 1) !== 0 || q_diff(c, 0) !== 0) begin
        miscompares++;
        $display("FAIL random streams ch%0d: got mh=%0d mc=%0d beats want %0d %0d", c,
                 obs_h[c].size(), obs_c[c].size(), exp_h[c].size(), exp_c[c].size());
      end
      vectors++;
      if (pkt_cnt[c*CB +: CB] !== m_pkt[c] || drop_cnt[c*CB +: CB] !== m_drop[c]) begin
        miscompares++;
        $display("FAIL random counters ch%0d: got pkt=%0d drop=%0d want %0d %0d", c,
                 pkt_cnt[c*CB +: CB], drop_cnt[c*CB +: CB], m_pkt[c], m_drop[c]);
      end
    end
    vectors++;
    if (viol !== v0) begin
      miscompares++;
      $display("FAIL handshake rules: got %0d violations want 0", viol - v0);
    end
    sync();
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      mode[c] = 2'd0; sd[c] = '0; sk[c] = '0; si[c] = '0; sl[c] = 1'b0; sv[c] = 1'b0;
      h_pat[c] = 0; c_pat[c] = 0;
    end
    test_reset();
    test_host_stream();
    test_broadcast();
    test_mode_switch();
    test_drop_clear();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
